register_writeback: RTL and testbench

REGISTER_WRITEBACK -- requirements
Module: register_writeback

---
 rtl/register_writeback.sv | 121 ++++++++++++
 tb/tb_register_writeback.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/register_writeback.sv
// rtl/register_writeback.sv - 8-entry register file fed by a 2-deep in-order write queue
// Optional empty-queue bypass: define REGISTER_WRITEBACK_BYPASS_EN.
module register_writeback #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [2:0]       writenum,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] reg0,
  output logic [WIDTH-1:0] reg1,
  output logic [WIDTH-1:0] reg2,
  output logic [WIDTH-1:0] reg3,
  output logic [WIDTH-1:0] reg4,
  output logic [WIDTH-1:0] reg5,
  output logic [WIDTH-1:0] reg6,
  output logic [WIDTH-1:0] reg7,
  output logic [7:0]       pending,
  output logic             busy
);

  logic [WIDTH-1:0] rf     [8];
  logic [2:0]       q_num  [2];
  logic [WIDTH-1:0] q_data [2];
  logic [1:0]       count;

  logic [2:0]       n_num  [2];
  logic [WIDTH-1:0] n_data [2];
  logic [1:0]       n_count;

  logic accept;
  logic retire;
  logic bypass;
  logic enqueue;

  assign wr_ready = reset_n && (count != 2'd2);
  assign accept   = wr_valid && wr_ready;
  assign retire   = (count != 2'd0);

`ifdef REGISTER_WRITEBACK_BYPASS_EN
  // An accept into an empty queue skips the queue and lands in the file directly.
  assign bypass = accept && (count == 2'd0);
`else
  assign bypass = 1'b0;
`endif

  assign enqueue = accept && !bypass;

  // Next queue state: pop the head first, then append the new write behind whatever remains.
  always_comb begin
    n_num   = q_num;
    n_data  = q_data;
    n_count = count;
    if (retire) begin
      n_num[0]  = q_num[1];
      n_data[0] = q_data[1];
      n_count   = count - 2'd1;
    end
    if (enqueue) begin
      n_num[n_count[0]]  = writenum;
      n_data[n_count[0]] = data_in;
      n_count            = n_count + 2'd1;
    end
  end

  // Queue storage and occupancy; reset drops any queued writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count     <= 2'd0;
      q_num[0]  <= 3'd0;
      q_num[1]  <= 3'd0;
      q_data[0] <= '0;
      q_data[1] <= '0;
    end else begin
      count  <= n_count;
      q_num  <= n_num;
      q_data <= n_data;
    end
  end

  // Register file: only the retiring head (or a bypassed write) modifies it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin
        rf[i] <= '0;
      end
    end else begin
      if (retire) begin
        rf[q_num[0]] <= q_data[0];
      end
      if (bypass) begin
        rf[writenum] <= data_in;
      end
    end
  end

  // Pending mask reflects only the live queue entries.
  always_comb begin
    pending = 8'd0;
    if (count != 2'd0) begin
      pending[q_num[0]] = 1'b1;
    end
    if (count == 2'd2) begin
      pending[q_num[1]] = 1'b1;
    end
  end

  assign busy = (count != 2'd0);

  assign reg0 = rf[0];
  assign reg1 = rf[1];
  assign reg2 = rf[2];
  assign reg3 = rf[3];
  assign reg4 = rf[4];
  assign reg5 = rf[5];
  assign reg6 = rf[6];
  assign reg7 = rf[7];

endmodule

// File: tb/tb_register_writeback.sv
// tb/tb_register_writeback.sv - self-checking bench for register_writeback
module tb_register_writeback;

`ifdef REGISTER_WRITEBACK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  writenum;
  logic [15:0] data_in;
  logic [15:0] reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7;
  logic [7:0]  pending;
  logic        busy;
  logic [15:0] dut_regs [8];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  n;
    logic [15:0] d;
  } ent_t;

  typedef struct {
    logic        v;
    logic [2:0]  n;
    logic [15:0] d;
    logic        exp_busy;
    logic [7:0]  exp_pend;
    logic [2:0]  chk_n;
    logic [15:0] chk_val;
  } vec_t;

  ent_t        m_q [$];
  logic [15:0] m_rf [8];
  vec_t        vec [4];

  always #5 clk = ~clk;

  register_writeback #(.WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .writenum(writenum), .data_in(data_in),
    .reg0(reg0), .reg1(reg1), .reg2(reg2), .reg3(reg3),
    .reg4(reg4), .reg5(reg5), .reg6(reg6), .reg7(reg7),
    .pending(pending), .busy(busy)
  );

  assign dut_regs[0] = reg0;
  assign dut_regs[1] = reg1;
  assign dut_regs[2] = reg2;
  assign dut_regs[3] = reg3;
  assign dut_regs[4] = reg4;
  assign dut_regs[5] = reg5;
  assign dut_regs[6] = reg6;
  assign dut_regs[7] = reg7;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    logic [7:0] exp_p;
    exp_p = 8'd0;
    foreach (m_q[k]) exp_p[m_q[k].n] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("reg%0d", i), {16'd0, dut_regs[i]}, {16'd0, m_rf[i]});
    end
    chk("pending", {24'd0, pending}, {24'd0, exp_p});
    chk("busy", {31'd0, busy}, {31'd0, (m_q.size() != 0)});
  endtask

  task automatic step(input logic v, input logic [2:0] n, input logic [15:0] d);
    logic acc;
    logic was_empty;
    ent_t e;
    wr_valid = v;
    writenum = n;
    data_in  = d;
    #1;
    chk("wr_ready", {31'd0, wr_ready}, {31'd0, (m_q.size() < 2)});
    acc       = v && (m_q.size() < 2);
    was_empty = (m_q.size() == 0);
    @(posedge clk);
    if (m_q.size() != 0) begin
      e = m_q.pop_front();
      m_rf[e.n] = e.d;
    end
    if (acc) begin
      if (BYP && was_empty) begin
        m_rf[n] = d;
      end else begin
        e.n = n;
        e.d = d;
        m_q.push_back(e);
      end
    end
    #1;
    check_state();
  endtask

  initial begin
    logic [15:0] val;
    reset_n  = 1'b0;
    wr_valid = 1'b0;
    writenum = 3'd0;
    data_in  = 16'd0;
    for (int i = 0; i < 8; i++) m_rf[i] = 16'd0;

    vec[0] = '{1'b1, 3'd3, 16'h00A5, !BYP, BYP ? 8'h00 : 8'h08, 3'd3, BYP ? 16'h00A5 : 16'h0000};
    vec[1] = '{1'b1, 3'd5, 16'hBEEF, !BYP, BYP ? 8'h00 : 8'h20, 3'd3, 16'h00A5};
    vec[2] = '{1'b1, 3'd5, 16'hCAFE, !BYP, BYP ? 8'h00 : 8'h20, 3'd5, BYP ? 16'hCAFE : 16'hBEEF};
    vec[3] = '{1'b0, 3'd0, 16'h0000, 1'b0, 8'h00, 3'd5, 16'hCAFE};

    // reset state
    @(posedge clk);
    #1;
    check_state();
    chk("reset_wr_ready", {31'd0, wr_ready}, 32'd0);
    #2;
    reset_n = 1'b1;

    // single write, then same-register ordering
    for (int r = 0; r < 4; r++) begin
      step(vec[r].v, vec[r].n, vec[r].d);
      chk($sformatf("tbl%0d_busy", r), {31'd0, busy}, {31'd0, vec[r].exp_busy});
      chk($sformatf("tbl%0d_pending", r), {24'd0, pending}, {24'd0, vec[r].exp_pend});
      chk($sformatf("tbl%0d_reg", r), {16'd0, dut_regs[vec[r].chk_n]}, {16'd0, vec[r].chk_val});
    end

    // three back-to-back writes
    step(1'b1, 3'd1, 16'h1111);
    step(1'b1, 3'd2, 16'h2222);
    step(1'b1, 3'd4, 16'h4444);
    step(1'b0, 3'd0, 16'h0000);
    step(1'b0, 3'd0, 16'h0000);
    chk("fill_reg1", {16'd0, reg1}, 32'h1111);
    chk("fill_reg2", {16'd0, reg2}, 32'h2222);
    chk("fill_reg4", {16'd0, reg4}, 32'h4444);

    // sustained throughput
    for (int i = 0; i < 8; i++) begin
      val = 16'(i) * 16'h0101;
      step(1'b1, 3'(i), val);
    end
    step(1'b0, 3'd0, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      val = 16'(i) * 16'h0101;
      chk($sformatf("thru_reg%0d", i), {16'd0, dut_regs[i]}, {16'd0, val});
    end

    // random traffic
    for (int i = 0; i < 40; i++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));
    end

    // reset mid-operation
    step(1'b1, 3'd6, 16'h0606);
    step(1'b1, 3'd7, 16'h0707);
    wr_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    m_q.delete();
    for (int i = 0; i < 8; i++) m_rf[i] = 16'd0;
    check_state();
    chk("midrst_wr_ready", {31'd0, wr_ready}, 32'd0);
    wr_valid = 1'b1;
    writenum = 3'd6;
    data_in  = 16'h5555;
    @(posedge clk);
    #1;
    check_state();
    chk("inrst_wr_ready", {31'd0, wr_ready}, 32'd0);
    wr_valid = 1'b0;
    #2;
    reset_n = 1'b1;
    step(1'b1, 3'd0, 16'h1234);
    step(1'b0, 3'd0, 16'h0000);
    step(1'b0, 3'd0, 16'h0000);
    chk("postrst_reg0", {16'd0, reg0}, 32'h1234);
    chk("postrst_reg6", {16'd0, reg6}, 32'h0000);
    chk("postrst_reg7", {16'd0, reg7}, 32'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
